// File: rtl/complex_butterfly_pipe_param.sv
// Radix-2 DIT butterfly: dout1 = din3 + din1*W, dout2 = din3 - din1*W.
// Pipeline: S1 products, optional S1b delay, S2 twiddle sum, S3 scale/saturate.
module complex_butterfly_pipe_param #(
   parameter int unsigned IWL1     = 16,
   parameter int unsigned IWL2     = 16,
   parameter int unsigned OWL      = 16,
   parameter int unsigned MUL_PIPE = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ce,
   input  logic                   strb_in,
   input  logic                   inv,
   input  logic [1:0]             scale_mode,
   input  logic signed [IWL1-1:0] din1_re,
   input  logic signed [IWL1-1:0] din1_im,
   input  logic signed [IWL2-1:0] din2_re,
   input  logic signed [IWL2-1:0] din2_im,
   input  logic signed [IWL1-1:0] din3_re,
   input  logic signed [IWL1-1:0] din3_im,
   output logic signed [OWL-1:0]  dout1_re,
   output logic signed [OWL-1:0]  dout1_im,
   output logic signed [OWL-1:0]  dout2_re,
   output logic signed [OWL-1:0]  dout2_im,
   output logic                   strb_out,
   output logic                   ovf_out,
   output logic                   ovf_sticky,
   input  logic                   ovf_clr
);
   localparam int unsigned PW   = IWL1 + IWL2;
   localparam int unsigned SW   = PW + 1;
   localparam int unsigned TW   = IWL1 + 2;
   localparam int unsigned AW   = IWL1 + 5;
   localparam int unsigned DROP = (OWL < IWL1) ? (IWL1 - OWL) : 32'd0;
   localparam int unsigned LIFT = (OWL > IWL1) ? (OWL - IWL1) : 32'd0;

   localparam logic signed [IWL2-1:0] W_MIN = {1'b1, {(IWL2-1){1'b0}}};
   localparam logic signed [IWL2-1:0] W_MAX = {1'b0, {(IWL2-1){1'b1}}};
   localparam logic signed [AW-1:0]   O_MAX = {{(AW-OWL+1){1'b0}}, {(OWL-1){1'b1}}};
   localparam logic signed [AW-1:0]   O_MIN = {{(AW-OWL+1){1'b1}}, {(OWL-1){1'b0}}};
   localparam logic signed [AW-1:0]   RND1  = AW'(1);
   localparam logic signed [AW-1:0]   RND2  = AW'(2);

   // S1 registers
   logic signed [PW-1:0]   p_rr_q, p_ii_q, p_ri_q, p_ir_q;
   logic signed [IWL1-1:0] d3r1_q, d3i1_q;
   logic [1:0]             sc1_q;
   logic                   v1_q;
   // Operands seen by S2 (after the optional delay stage)
   logic signed [PW-1:0]   p_rr_m, p_ii_m, p_ri_m, p_ir_m;
   logic signed [IWL1-1:0] d3r_m, d3i_m;
   logic [1:0]             sc_m;
   logic                   v_m;
   // S2 registers
   logic signed [TW-1:0]   t_re_q, t_im_q;
   logic signed [IWL1-1:0] d3r2_q, d3i2_q;
   logic [1:0]             sc2_q;
   logic                   v2_q;
   // S3 / output registers
   logic signed [OWL-1:0]  d1r_q, d1i_q, d2r_q, d2i_q;
   logic                   strb_q, ovf_q, sticky_q;

   // Twiddle conjugation (saturating negate) and the four partial products
   logic signed [IWL2-1:0] w_im_c;
   logic signed [PW-1:0]   p_rr_d, p_ii_d, p_ri_d, p_ir_d;
   always_comb begin
      w_im_c = din2_im;
      if (inv) w_im_c = (din2_im == W_MIN) ? W_MAX : -din2_im;
      p_rr_d = PW'(din1_re) * PW'(din2_re);
      p_ii_d = PW'(din1_im) * PW'(w_im_c);
      p_ri_d = PW'(din1_re) * PW'(w_im_c);
      p_ir_d = PW'(din1_im) * PW'(din2_re);
   end

   // S1: register products with aligned din3, scale and valid
   always_ff @(posedge clk) begin
      if (!rst) begin
         p_rr_q <= '0; p_ii_q <= '0; p_ri_q <= '0; p_ir_q <= '0;
         d3r1_q <= '0; d3i1_q <= '0; sc1_q <= '0; v1_q <= 1'b0;
      end else if (ce) begin
         p_rr_q <= p_rr_d; p_ii_q <= p_ii_d; p_ri_q <= p_ri_d; p_ir_q <= p_ir_d;
         d3r1_q <= din3_re; d3i1_q <= din3_im; sc1_q <= scale_mode; v1_q <= strb_in;
      end
   end

   if (MUL_PIPE != 0) begin : g_mpipe
      logic signed [PW-1:0]   p_rr_b_q, p_ii_b_q, p_ri_b_q, p_ir_b_q;
      logic signed [IWL1-1:0] d3r_b_q, d3i_b_q;
      logic [1:0]             sc_b_q;
      logic                   v_b_q;
      // S1b: pure delay of every S1 register
      always_ff @(posedge clk) begin
         if (!rst) begin
            p_rr_b_q <= '0; p_ii_b_q <= '0; p_ri_b_q <= '0; p_ir_b_q <= '0;
            d3r_b_q <= '0; d3i_b_q <= '0; sc_b_q <= '0; v_b_q <= 1'b0;
         end else if (ce) begin
            p_rr_b_q <= p_rr_q; p_ii_b_q <= p_ii_q; p_ri_b_q <= p_ri_q; p_ir_b_q <= p_ir_q;
            d3r_b_q <= d3r1_q; d3i_b_q <= d3i1_q; sc_b_q <= sc1_q; v_b_q <= v1_q;
         end
      end
      assign p_rr_m = p_rr_b_q; assign p_ii_m = p_ii_b_q;
      assign p_ri_m = p_ri_b_q; assign p_ir_m = p_ir_b_q;
      assign d3r_m = d3r_b_q; assign d3i_m = d3i_b_q;
      assign sc_m = sc_b_q; assign v_m = v_b_q;
   end else begin : g_nopipe
      assign p_rr_m = p_rr_q; assign p_ii_m = p_ii_q;
      assign p_ri_m = p_ri_q; assign p_ir_m = p_ir_q;
      assign d3r_m = d3r1_q; assign d3i_m = d3i1_q;
      assign sc_m = sc1_q; assign v_m = v1_q;
   end

   // S2 arithmetic: complex product, arithmetic floor shift back to data scale
   logic signed [SW-1:0] t_re_w, t_im_w;
   logic signed [TW-1:0] t_re_d, t_im_d;
   always_comb begin
      t_re_w = (SW'(p_rr_m) - SW'(p_ii_m)) >>> (IWL2 - 1);
      t_im_w = (SW'(p_ri_m) + SW'(p_ir_m)) >>> (IWL2 - 1);
      t_re_d = TW'(t_re_w);
      t_im_d = TW'(t_im_w);
   end

   // S2: register twiddled product alongside delayed din3
   always_ff @(posedge clk) begin
      if (!rst) begin
         t_re_q <= '0; t_im_q <= '0; d3r2_q <= '0; d3i2_q <= '0;
         sc2_q <= '0; v2_q <= 1'b0;
      end else if (ce) begin
         t_re_q <= t_re_d; t_im_q <= t_im_d; d3r2_q <= d3r_m; d3i2_q <= d3i_m;
         sc2_q <= sc_m; v2_q <= v_m;
      end
   end

   // One output leg: round-half-up scale, align to OWL, saturate; MSB of result is overflow
   function automatic logic [OWL:0] leg(input logic signed [AW-1:0] s, input logic [1:0] sc);
      logic signed [AW-1:0] r;
      logic signed [AW-1:0] a;
      logic                 hi, lo;
      case (sc)
         2'd0:    r = s;
         2'd1:    r = (s + RND1) >>> 1;
         default: r = (s + RND2) >>> 2;
      endcase
      a  = (r >>> DROP) <<< LIFT;
      hi = (a > O_MAX);
      lo = (a < O_MIN);
      if (hi)      leg = {1'b1, OWL'(O_MAX)};
      else if (lo) leg = {1'b1, OWL'(O_MIN)};
      else         leg = {1'b0, OWL'(a)};
   endfunction

   // S3 arithmetic: butterfly sums at extended width, then per-leg scaling
   logic signed [AW-1:0] s1r_w, s1i_w, s2r_w, s2i_w;
   logic [OWL:0]         l1r_d, l1i_d, l2r_d, l2i_d;
   always_comb begin
      s1r_w = AW'(d3r2_q) + AW'(t_re_q);
      s1i_w = AW'(d3i2_q) + AW'(t_im_q);
      s2r_w = AW'(d3r2_q) - AW'(t_re_q);
      s2i_w = AW'(d3i2_q) - AW'(t_im_q);
      l1r_d = leg(s1r_w, sc2_q);
      l1i_d = leg(s1i_w, sc2_q);
      l2r_d = leg(s2r_w, sc2_q);
      l2i_d = leg(s2i_w, sc2_q);
   end

   // S3: outputs load only for valid samples; strobe is valid & ce, so each result flags once
   always_ff @(posedge clk) begin
      if (!rst) begin
         d1r_q <= '0; d1i_q <= '0; d2r_q <= '0; d2i_q <= '0;
         strb_q <= 1'b0; ovf_q <= 1'b0; sticky_q <= 1'b0;
      end else begin
         strb_q <= ce & v2_q;
         if (ce && v2_q) begin
            d1r_q <= l1r_d[OWL-1:0]; d1i_q <= l1i_d[OWL-1:0];
            d2r_q <= l2r_d[OWL-1:0]; d2i_q <= l2i_d[OWL-1:0];
            ovf_q <= l1r_d[OWL] | l1i_d[OWL] | l2r_d[OWL] | l2i_d[OWL];
         end
         sticky_q <= (strb_q & ovf_q) | (sticky_q & ~ovf_clr);
      end
   end

   assign dout1_re   = d1r_q;
   assign dout1_im   = d1i_q;
   assign dout2_re   = d2r_q;
   assign dout2_im   = d2i_q;
   assign strb_out   = strb_q;
   assign ovf_out    = ovf_q;
   assign ovf_sticky = sticky_q;
endmodule

// File: tb/tb_complex_butterfly_pipe_param.sv
// Scoreboard bench for complex_butterfly_pipe_param (16/16/16, MUL_PIPE=1).
module tb_complex_butterfly_pipe_param;
   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst, ce, strb_in, inv, ovf_clr;
   logic [1:0]  scale_mode;
   logic [15:0] din1_re, din1_im, din2_re, din2_im, din3_re, din3_im;
   logic [15:0] dout1_re, dout1_im, dout2_re, dout2_im;
   logic        strb_out, ovf_out, ovf_sticky;

   always #5 clk = ~clk;

   complex_butterfly_pipe_param #(.IWL1(16), .IWL2(16), .OWL(16), .MUL_PIPE(1)) dut (
      .clk(clk), .rst(rst), .ce(ce), .strb_in(strb_in), .inv(inv), .scale_mode(scale_mode),
      .din1_re(din1_re), .din1_im(din1_im), .din2_re(din2_re), .din2_im(din2_im),
      .din3_re(din3_re), .din3_im(din3_im),
      .dout1_re(dout1_re), .dout1_im(dout1_im), .dout2_re(dout2_re), .dout2_im(dout2_im),
      .strb_out(strb_out), .ovf_out(ovf_out), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr));

   typedef struct {
      string       name;
      logic [15:0] d1r, d1i, d2r, d2i;
      logic        ovf;
      int          lat;
      int          issued;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: pop one expectation per output strobe
   always @(negedge clk) begin
      if (strb_out === 1'b1) begin
         if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strb: got strobe at cycle %0d expected none", cyc);
         end else begin
            mon_e = sbq.pop_front();
            chk({mon_e.name, "_d1re"}, 32'(dout1_re), 32'(mon_e.d1r));
            chk({mon_e.name, "_d1im"}, 32'(dout1_im), 32'(mon_e.d1i));
            chk({mon_e.name, "_d2re"}, 32'(dout2_re), 32'(mon_e.d2r));
            chk({mon_e.name, "_d2im"}, 32'(dout2_im), 32'(mon_e.d2i));
            chk({mon_e.name, "_ovf"},  32'(ovf_out),  32'(mon_e.ovf));
            chk({mon_e.name, "_lat"},  32'(cyc - mon_e.issued), 32'(mon_e.lat));
         end
      end
   end

   task automatic issue(input string nm,
                        input logic [15:0] a_re, a_im, w_re, w_im, b_re, b_im,
                        input logic iv, input logic [1:0] sc,
                        input logic [15:0] e1r, e1i, e2r, e2i, input logic eo,
                        input int lat, input bit push);
      exp_t e;
      @(negedge clk);
      ce = 1'b1; strb_in = 1'b1; inv = iv; scale_mode = sc;
      din1_re = a_re; din1_im = a_im; din2_re = w_re; din2_im = w_im;
      din3_re = b_re; din3_im = b_im;
      if (push) begin
         e.name = nm; e.d1r = e1r; e.d1i = e1i; e.d2r = e2r; e.d2i = e2i;
         e.ovf = eo; e.lat = lat; e.issued = cyc;
         sbq.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ce = 1'b1; strb_in = 1'b0;
      end
   endtask

   task automatic drain();
      int k = 0;
      while (sbq.size() != 0 && k < 40) begin
         @(negedge clk);
         ce = 1'b1; strb_in = 1'b0;
         k++;
      end
      if (sbq.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_d1re"}, 32'(dout1_re), 32'h0);
      chk({tag, "_d1im"}, 32'(dout1_im), 32'h0);
      chk({tag, "_d2re"}, 32'(dout2_re), 32'h0);
      chk({tag, "_d2im"}, 32'(dout2_im), 32'h0);
      chk({tag, "_strb"}, 32'(strb_out), 32'h0);
      chk({tag, "_ovf"},  32'(ovf_out),  32'h0);
      chk({tag, "_stky"}, 32'(ovf_sticky), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; ce = 1'b1; strb_in = 1'b0; inv = 1'b0; ovf_clr = 1'b0; scale_mode = 2'd0;
      din1_re = '0; din1_im = '0; din2_re = '0; din2_im = '0; din3_re = '0; din3_im = '0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b1;

      // Basic butterfly, scale 0 and 1
      issue("t1_s0", 16'h2000, 0, 16'h4000, 0, 16'h1000, 0, 0, 2'd0, 16'h2000, 0, 16'h0000, 0, 0, LAT, 1);
      issue("t1_s1", 16'h2000, 0, 16'h4000, 0, 16'h1000, 0, 0, 2'd1, 16'h1000, 0, 16'h0000, 0, 0, LAT, 1);
      // Conjugation and its saturating negate
      issue("t2_inv1", 16'h2000, 0, 0, 16'h4000, 0, 0, 1, 2'd0, 0, 16'hF000, 0, 16'h1000, 0, LAT, 1);
      issue("t2_inv0", 16'h2000, 0, 0, 16'h4000, 0, 0, 0, 2'd0, 0, 16'h1000, 0, 16'hF000, 0, LAT, 1);
      issue("t2_wsat", 16'h4000, 0, 0, 16'h8000, 0, 0, 1, 2'd0, 0, 16'h3FFF, 0, 16'hC001, 0, LAT, 1);
      // Rounding with scale 1 on odd values, scale 3 behaves as 2
      issue("rnd_s1", 0, 0, 16'h4000, 0, 16'h0003, 16'hFFFD, 0, 2'd1, 16'h0002, 16'hFFFF, 16'h0002, 16'hFFFF, 0, LAT, 1);
      issue("rnd_s3", 0, 0, 16'h4000, 0, 16'h0006, 16'h0005, 0, 2'd3, 16'h0002, 16'h0001, 16'h0002, 16'h0001, 0, LAT, 1);
      drain();

      // Positive saturation and sticky clear
      issue("t3_pos", 16'h7000, 0, 16'h7FFF, 0, 16'h7000, 0, 0, 2'd0, 16'h7FFF, 0, 16'h0001, 0, 1, LAT, 1);
      drain();
      idle(1);
      chk("t3_sticky_set", 32'(ovf_sticky), 32'h1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("t3_sticky_clr", 32'(ovf_sticky), 32'h0);

      // Negative saturation with clear on the same cycle as the set
      issue("t3_neg", 16'h8000, 0, 16'h7FFF, 0, 16'h8000, 0, 0, 2'd0, 16'h8000, 0, 16'hFFFF, 0, 1, LAT, 1);
      idle(4);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("t3_set_wins", 32'(ovf_sticky), 32'h1);
      drain();

      // Eight back-to-back samples, scale 2, W = 0.5
      issue("bb0", 16'h0006, 16'h0002, 16'h4000, 0, 16'h0001, 16'h0003, 0, 2'd2, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 0, LAT, 1);
      issue("bb1", 16'h0002, 16'h0000, 16'h4000, 0, 16'h0002, 16'h0005, 0, 2'd2, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 0, LAT, 1);
      issue("bb2", 16'hFFFE, 16'hFFFA, 16'h4000, 0, 16'h0000, 16'hFFFF, 0, 2'd2, 16'h0000, 16'hFFFF, 16'h0000, 16'h0001, 0, LAT, 1);
      issue("bb3", 16'h0003, 16'hFFFD, 16'h4000, 0, 16'h0004, 16'h0000, 0, 2'd2, 16'h0001, 16'h0000, 16'h0001, 16'h0001, 0, LAT, 1);
      issue("bb4", 16'h1000, 16'h0800, 16'h4000, 0, 16'h2000, 16'h1000, 0, 2'd2, 16'h0A00, 16'h0500, 16'h0600, 16'h0300, 0, LAT, 1);
      issue("bb5", 16'h8000, 16'h7FFF, 16'h4000, 0, 16'h7FFF, 16'h8000, 0, 2'd2, 16'h1000, 16'hF000, 16'h3000, 16'hD000, 0, LAT, 1);
      issue("bb6", 16'h0001, 16'hFFFF, 16'h4000, 0, 16'h0001, 16'h0001, 0, 2'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 0, LAT, 1);
      issue("bb7", 16'h0000, 16'h0000, 16'h4000, 0, 16'h0006, 16'hFFFA, 0, 2'd2, 16'h0002, 16'hFFFF, 16'h0002, 16'hFFFF, 0, LAT, 1);
      drain();

      // Three-cycle stall with two samples in flight; strobes during the stall must be ignored
      issue("st_a", 16'h2000, 0, 16'h4000, 0, 16'h1000, 0, 0, 2'd0, 16'h2000, 0, 0, 0, 0, LAT + 3, 1);
      issue("st_b", 0, 16'h2000, 16'h4000, 0, 0, 16'h1000, 0, 2'd0, 0, 16'h2000, 0, 0, 0, LAT + 3, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ce = 1'b0; strb_in = 1'b1; din1_re = 16'h1234; din3_re = 16'h0555;
      end
      drain();

      // Reset with three samples in flight
      issue("rs0", 16'h2000, 0, 16'h4000, 0, 16'h1000, 0, 0, 2'd0, 0, 0, 0, 0, 0, LAT, 0);
      issue("rs1", 16'h7000, 0, 16'h7FFF, 0, 16'h7000, 0, 0, 2'd0, 0, 0, 0, 0, 0, LAT, 0);
      issue("rs2", 16'h0100, 0, 16'h4000, 0, 16'h0100, 0, 0, 2'd0, 0, 0, 0, 0, 0, LAT, 0);
      @(negedge clk);
      strb_in = 1'b0; rst = 1'b0;
      @(negedge clk);
      chk_zero("midrst");
      rst = 1'b1;
      idle(6);
      issue("post_rst", 16'h0100, 0, 16'h4000, 0, 16'h0100, 0, 0, 2'd0, 16'h0180, 0, 16'h0080, 0, 0, LAT, 1);
      drain();
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
